pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/milano_pkg.sv | 15 +
 rtl/hazard_detect.sv | 36 +++
 rtl/pipe_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/milano_pkg.sv
// rtl/milano_pkg.sv - shared types and constants for the pipeline control block
package milano_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_WAIT  = 2'd1,
        LSU_WAIT = 2'd2
    } ctrl_state_e;

    localparam int unsigned MD_MAX_CYCLES_DEF = 40;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned CSR_ADDR_W = 12;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use and CSR read-after-write detection
module hazard_detect
    import milano_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic                  id_csr_sel,
    input  logic [CSR_ADDR_W-1:0] id_csr_addr,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_rd_wr_en,
    input  logic                  ex_lsu_req,
    input  logic                  ex_lsu_we,
    input  logic                  ex_csr_wr_en,
    input  logic [CSR_ADDR_W-1:0] ex_csr_addr,
    output logic                  hazard
);

    logic ex_load;
    logic rs1_match;
    logic rs2_match;
    logic load_use;
    logic csr_raw;

    // x0 is hardwired to zero, so a load targeting it never produces data to wait on
    assign ex_load   = ex_lsu_req && !ex_lsu_we && ex_rd_wr_en && (ex_rd_addr != '0);
    assign rs1_match = id_rs1_used && (id_rs1_addr == ex_rd_addr);
    assign rs2_match = id_rs2_used && (id_rs2_addr == ex_rd_addr);
    assign load_use  = ex_load && (rs1_match || rs2_match);

    assign csr_raw   = ex_csr_wr_en && id_csr_sel && (ex_csr_addr == id_csr_addr);

    assign hazard    = load_use || csr_raw;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller with multiply/divide watchdog
module pipe_ctrl
    import milano_pkg::*;
#(
    parameter int unsigned MD_MAX_CYCLES = MD_MAX_CYCLES_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic                  id_csr_sel_i,
    input  logic [CSR_ADDR_W-1:0] id_csr_addr_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
    input  logic                  ex_rd_wr_en_i,
    input  logic                  ex_lsu_req_i,
    input  logic                  ex_lsu_we_i,
    input  logic                  ex_md_sel_i,
    input  logic                  ex_csr_wr_en_i,
    input  logic [CSR_ADDR_W-1:0] ex_csr_addr_i,
    input  logic                  ex_jump_taken_i,
    input  logic                  md_done_i,
    input  logic                  lsu_rvalid_i,
    output logic                  stall_pc_o,
    output logic                  stall_ifid_o,
    output logic                  stall_idex_o,
    output logic                  flush_ifid_o,
    output logic                  bubble_idex_o,
    output logic                  md_start_o,
    output logic                  md_timeout_o,
    output ctrl_state_e           ctrl_state_o
);

    localparam int unsigned     CW        = $clog2(MD_MAX_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LIMIT = CW'(MD_MAX_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_SAT   = {CW{1'b1}};

    ctrl_state_e   state;
    ctrl_state_e   state_next;
    logic [CW-1:0] md_cnt;
    logic [CW-1:0] md_cnt_next;
    logic          hazard;

    logic stall_pc;
    logic stall_ifid;
    logic stall_idex;
    logic flush_ifid;
    logic bubble_idex;
    logic md_start;
    logic md_timeout;

    hazard_detect u_hazard_detect (
        .id_rs1_addr  (id_rs1_addr_i),
        .id_rs2_addr  (id_rs2_addr_i),
        .id_rs1_used  (id_rs1_used_i),
        .id_rs2_used  (id_rs2_used_i),
        .id_csr_sel   (id_csr_sel_i),
        .id_csr_addr  (id_csr_addr_i),
        .ex_rd_addr   (ex_rd_addr_i),
        .ex_rd_wr_en  (ex_rd_wr_en_i),
        .ex_lsu_req   (ex_lsu_req_i),
        .ex_lsu_we    (ex_lsu_we_i),
        .ex_csr_wr_en (ex_csr_wr_en_i),
        .ex_csr_addr  (ex_csr_addr_i),
        .hazard       (hazard)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            state  <= state_next;
            md_cnt <= md_cnt_next;
        end
    end

    always_comb begin
        state_next  = state;
        md_cnt_next = md_cnt;
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        stall_idex  = 1'b0;
        flush_ifid  = 1'b0;
        bubble_idex = 1'b0;
        md_start    = 1'b0;
        md_timeout  = 1'b0;

        case (state)
            RUN: begin
                if (ex_jump_taken_i) begin
                    flush_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                end else if (ex_md_sel_i) begin
                    md_start    = 1'b1;
                    stall_pc    = 1'b1;
                    stall_ifid  = 1'b1;
                    stall_idex  = 1'b1;
                    md_cnt_next = '0;
                    state_next  = MD_WAIT;
                end else if (ex_lsu_req_i && !lsu_rvalid_i) begin
                    stall_pc    = 1'b1;
                    stall_ifid  = 1'b1;
                    stall_idex  = 1'b1;
                    state_next  = LSU_WAIT;
                end else if (hazard) begin
                    // Hold fetch/decode and let EX drain into a bubble for one cycle
                    stall_pc    = 1'b1;
                    stall_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                end
            end

            MD_WAIT: begin
                if (md_cnt != CNT_SAT) begin
                    md_cnt_next = md_cnt + CW'(1);
                end
                if (md_done_i) begin
                    state_next = RUN;
                end else if (md_cnt >= CNT_LIMIT) begin
                    md_timeout = 1'b1;
                    state_next = RUN;
                end else begin
                    stall_pc   = 1'b1;
                    stall_ifid = 1'b1;
                    stall_idex = 1'b1;
                end
            end

            LSU_WAIT: begin
                if (lsu_rvalid_i) begin
                    state_next = RUN;
                end else begin
                    stall_pc   = 1'b1;
                    stall_ifid = 1'b1;
                    stall_idex = 1'b1;
                end
            end

            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Reset masks every output so nothing leaks out while the state register is still stale
    assign stall_pc_o    = rst_ni && stall_pc;
    assign stall_ifid_o  = rst_ni && stall_ifid;
    assign stall_idex_o  = rst_ni && stall_idex;
    assign flush_ifid_o  = rst_ni && flush_ifid;
    assign bubble_idex_o = rst_ni && bubble_idex;
    assign md_start_o    = rst_ni && md_start;
    assign md_timeout_o  = rst_ni && md_timeout;
    assign ctrl_state_o  = rst_ni ? state : RUN;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard testbench for pipe_ctrl
module tb_pipe_ctrl;
    import milano_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic        id_rs1_used, id_rs2_used, id_csr_sel;
    logic [11:0] id_csr_addr, ex_csr_addr;
    logic        ex_rd_wr_en, ex_lsu_req, ex_lsu_we, ex_md_sel, ex_csr_wr_en;
    logic        ex_jump_taken, md_done, lsu_rvalid;

    logic        spc, sif, sidx, fl, bub, mds, mto;
    logic        spc8, sif8, sidx8, fl8, bub8, mds8, mto8;
    ctrl_state_e st, st8;

    localparam logic [6:0] O_NONE  = 7'b000_00_0_0;
    localparam logic [6:0] O_STALL = 7'b111_00_0_0;
    localparam logic [6:0] O_START = 7'b111_00_1_0;
    localparam logic [6:0] O_LU    = 7'b110_01_0_0;
    localparam logic [6:0] O_JMP   = 7'b000_11_0_0;
    localparam logic [6:0] O_TMO   = 7'b000_00_0_1;

    typedef struct {
        string      tag;
        bit         dut8;
        logic [8:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    sb_entry_t ent;
    int errors = 0;
    int checks = 0;

    logic [8:0] obs, obs8;
    assign obs  = {spc, sif, sidx, fl, bub, mds, mto, 2'(st)};
    assign obs8 = {spc8, sif8, sidx8, fl8, bub8, mds8, mto8, 2'(st8)};

    always #5 clk = ~clk;

    pipe_ctrl u_dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .id_rs1_addr_i(id_rs1_addr), .id_rs2_addr_i(id_rs2_addr),
        .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
        .id_csr_sel_i(id_csr_sel), .id_csr_addr_i(id_csr_addr),
        .ex_rd_addr_i(ex_rd_addr), .ex_rd_wr_en_i(ex_rd_wr_en),
        .ex_lsu_req_i(ex_lsu_req), .ex_lsu_we_i(ex_lsu_we),
        .ex_md_sel_i(ex_md_sel), .ex_csr_wr_en_i(ex_csr_wr_en),
        .ex_csr_addr_i(ex_csr_addr), .ex_jump_taken_i(ex_jump_taken),
        .md_done_i(md_done), .lsu_rvalid_i(lsu_rvalid),
        .stall_pc_o(spc), .stall_ifid_o(sif), .stall_idex_o(sidx),
        .flush_ifid_o(fl), .bubble_idex_o(bub),
        .md_start_o(mds), .md_timeout_o(mto), .ctrl_state_o(st)
    );

    pipe_ctrl #(.MD_MAX_CYCLES(8)) u_dut8 (
        .clk_i(clk), .rst_ni(rst_ni),
        .id_rs1_addr_i(id_rs1_addr), .id_rs2_addr_i(id_rs2_addr),
        .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
        .id_csr_sel_i(id_csr_sel), .id_csr_addr_i(id_csr_addr),
        .ex_rd_addr_i(ex_rd_addr), .ex_rd_wr_en_i(ex_rd_wr_en),
        .ex_lsu_req_i(ex_lsu_req), .ex_lsu_we_i(ex_lsu_we),
        .ex_md_sel_i(ex_md_sel), .ex_csr_wr_en_i(ex_csr_wr_en),
        .ex_csr_addr_i(ex_csr_addr), .ex_jump_taken_i(ex_jump_taken),
        .md_done_i(md_done), .lsu_rvalid_i(lsu_rvalid),
        .stall_pc_o(spc8), .stall_ifid_o(sif8), .stall_idex_o(sidx8),
        .flush_ifid_o(fl8), .bubble_idex_o(bub8),
        .md_start_o(mds8), .md_timeout_o(mto8), .ctrl_state_o(st8)
    );

    task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%b expected=%b (spc,sif,sidx,fl,bub,start,tmo,state)", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            ent = sb_q.pop_front();
            check_eq(ent.tag, ent.dut8 ? obs8 : obs, ent.exp);
        end
    end

    task automatic push(input string tag, input bit d8, input ctrl_state_e s, input logic [6:0] o);
        sb_entry_t n;
        n.tag  = tag;
        n.dut8 = d8;
        n.exp  = {o, 2'(s)};
        sb_q.push_back(n);
    endtask

    task automatic idle();
        id_rs1_addr = '0; id_rs2_addr = '0; id_rs1_used = 0; id_rs2_used = 0;
        id_csr_sel = 0; id_csr_addr = '0; ex_rd_addr = '0; ex_rd_wr_en = 0;
        ex_lsu_req = 0; ex_lsu_we = 0; ex_md_sel = 0; ex_csr_wr_en = 0;
        ex_csr_addr = '0; ex_jump_taken = 0; md_done = 0; lsu_rvalid = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic load(input logic [4:0] rd);
        ex_lsu_req = 1; ex_lsu_we = 0; ex_rd_wr_en = 1; ex_rd_addr = rd;
    endtask

    initial begin
        rst_ni = 0;
        idle();

        cyc(); ex_md_sel = 1; ex_jump_taken = 1;
        push("rst_outs", 0, RUN, O_NONE); push("rst_outs8", 1, RUN, O_NONE);
        cyc(); push("rst_hold", 0, RUN, O_NONE);
        cyc(); rst_ni = 1; push("post_rst", 0, RUN, O_NONE);
        cyc(); md_done = 1; lsu_rvalid = 1; push("ign_resp", 0, RUN, O_NONE);
        cyc(); push("ign_resp_next", 0, RUN, O_NONE);

        cyc(); load(5); id_rs1_addr = 5; id_rs1_used = 1; lsu_rvalid = 1;
        push("lu_rs1", 0, RUN, O_LU);
        cyc(); push("lu_after", 0, RUN, O_NONE);
        cyc(); load(0); id_rs1_addr = 0; id_rs1_used = 1; lsu_rvalid = 1;
        push("lu_x0", 0, RUN, O_NONE);
        cyc(); load(7); id_rs2_addr = 7; id_rs2_used = 1; lsu_rvalid = 1;
        push("lu_rs2", 0, RUN, O_LU);
        cyc(); load(7); id_rs1_addr = 7; id_rs2_addr = 7; lsu_rvalid = 1;
        push("lu_unused", 0, RUN, O_NONE);
        cyc(); load(9); ex_lsu_we = 1; id_rs1_addr = 9; id_rs1_used = 1; lsu_rvalid = 1;
        push("store_no_lu", 0, RUN, O_NONE);
        cyc(); load(5); id_rs1_addr = 5; id_rs1_used = 1; lsu_rvalid = 1; ex_jump_taken = 1;
        push("jmp_lu", 0, RUN, O_JMP);

        cyc(); ex_csr_wr_en = 1; ex_csr_addr = 12'h300; id_csr_sel = 1; id_csr_addr = 12'h300;
        push("csr_raw", 0, RUN, O_LU);
        cyc(); push("csr_after", 0, RUN, O_NONE);
        cyc(); ex_csr_wr_en = 1; ex_csr_addr = 12'h300; id_csr_sel = 1; id_csr_addr = 12'h305;
        push("csr_diff", 0, RUN, O_NONE);

        cyc(); ex_md_sel = 1; push("md_start", 0, RUN, O_START);
        for (int i = 1; i <= 10; i++) begin
            cyc(); ex_md_sel = 1; push("md_wait", 0, MD_WAIT, O_STALL);
        end
        cyc(); ex_md_sel = 1; md_done = 1; push("md_done", 0, MD_WAIT, O_NONE);
        cyc(); push("md_back", 0, RUN, O_NONE);

        cyc(); ex_md_sel = 1; push("b2b_start1", 0, RUN, O_START);
        cyc(); ex_md_sel = 1; md_done = 1; push("b2b_done1", 0, MD_WAIT, O_NONE);
        cyc(); ex_md_sel = 1; push("b2b_start2", 0, RUN, O_START);
        cyc(); ex_md_sel = 1; md_done = 1; push("b2b_done2", 0, MD_WAIT, O_NONE);
        cyc(); push("b2b_back", 0, RUN, O_NONE);

        cyc(); load(3); push("lsu_req", 0, RUN, O_STALL);
        cyc(); load(3); push("lsu_wait1", 0, LSU_WAIT, O_STALL);
        cyc(); load(3); ex_jump_taken = 1; push("lsu_wait_jmp", 0, LSU_WAIT, O_STALL);
        cyc(); load(3); ex_md_sel = 1; push("lsu_wait_md", 0, LSU_WAIT, O_STALL);
        cyc(); load(3); lsu_rvalid = 1; push("lsu_rvalid", 0, LSU_WAIT, O_NONE);
        cyc(); push("lsu_back", 0, RUN, O_NONE);

        cyc(); load(3); push("lsu2_req", 0, RUN, O_STALL);
        cyc(); load(3); push("lsu2_wait", 0, LSU_WAIT, O_STALL);
        cyc(); load(3); rst_ni = 0; push("lsu2_rst", 0, RUN, O_NONE);
        cyc(); rst_ni = 1; lsu_rvalid = 1; push("lsu2_after_rst", 0, RUN, O_NONE);
        cyc(); push("lsu2_idle", 0, RUN, O_NONE);

        cyc(); ex_md_sel = 1; push("to_start", 1, RUN, O_START);
        for (int i = 1; i <= 7; i++) begin
            cyc(); ex_md_sel = 1; push("to_wait", 1, MD_WAIT, O_STALL);
        end
        cyc(); ex_md_sel = 1; push("to_pulse", 1, MD_WAIT, O_TMO);
        push("to_main_no_tmo", 0, MD_WAIT, O_STALL);
        cyc(); push("to_back", 1, RUN, O_NONE); push("main_still_wait", 0, MD_WAIT, O_STALL);
        cyc(); rst_ni = 0; push("md_rst", 0, RUN, O_NONE); push("md_rst8", 1, RUN, O_NONE);
        cyc(); rst_ni = 1; push("md_rst_after", 0, RUN, O_NONE);

        cyc(); ex_md_sel = 1; push("dw_start", 1, RUN, O_START);
        for (int i = 1; i <= 7; i++) begin
            cyc(); ex_md_sel = 1; push("dw_wait", 1, MD_WAIT, O_STALL);
        end
        cyc(); ex_md_sel = 1; md_done = 1;
        push("done_wins", 1, MD_WAIT, O_NONE); push("done_main", 0, MD_WAIT, O_NONE);
        cyc(); push("dw_back", 1, RUN, O_NONE); push("dw_back_main", 0, RUN, O_NONE);

        cyc();
        cyc();
        check_eq("sb_drain", 9'(sb_q.size()), 9'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
